cube_pwl: RTL and testbench
===========================

// Module: cube_pwl
// PURPOSE
//  Piecewise-linear cube y = x^3, the inverse companion of the cube-root block. Used in the Lab->RGB path
//  (inverse f(t)), with x, y as unsigned fractions of 2^DSIZE. After reset an internal FSM builds a 17-entry
//  breakpoint table (16 segments), then raises cal_valid. From then on, a 3-stage pipeline streams one sample per clock.
// PARAMETERS
//  DSIZE    16   data width of X and Y; legal range DSIZE >= 12
//  SEG_BITS 4    log2(segment count); fixed at 4, taken from package
// PORTS
//  clock      in   1      single clock, all logic on posedge
//  rst_n      in   1      asynchronous, active-low reset
//  X          in   DSIZE  input sample, sampled every clock
//  Y          out  DSIZE  approximated X^3 / 2^(2*DSIZE), 3-cycle latency
//  cal_valid  out  1      1 = table built, Y meaningful; stays 1 until next reset
// BEHAVIOUR
//  Reset: Y=0, cal_valid=0, table cleared, FSM=S_SQ with k=0; all pipeline registers = 0.
//  Table: P_k = min(k^3 << (DSIZE-12), 2^DSIZE-1), k=0..16; C_k=P_k, M_k=P_{k+1}-P_k for k=0..15.
//   DSIZE=16: P_k=16*k^3; P15=54000, P16 clamps 65536->65535, so M15=11535.
//  Build FSM: S_SQ (sq=k*k) -> S_CU (cu=sq*k) -> S_ST (P[k]=clamp(cu<<(DSIZE-12)); if k>0 then M[k-1]=P[k]-P[k-1]).
//   From S_ST: k==16 -> S_DONE, else k++ -> S_SQ. In S_DONE, cal_valid=1 (registered); S_DONE is terminal.
//   Build time: 51 cycles from reset release to cal_valid=1. Input X is ignored during build.
//  Datapath (active only when cal_valid=1; otherwise stage registers hold 0, so Y=0):
//   S1: seg=X[DSIZE-1 -: 4], frac=X[DSIZE-5:0]; register M[seg], C[seg], frac.
//   S2: prod = M*frac, width DSIZE+DSIZE-4, unsigned, no truncation.
//   S3: Y = C + (prod >> (DSIZE-4)); the sum saturates at 2^DSIZE-1 (cannot exceed it by construction;
//       the saturation is a guard).
//  Latency: X at edge n -> Y at edge n+3. Throughput 1/clk. No back-pressure and no input valid.
//  First valid Y appears 3 cycles after cal_valid rises. Y is exact at every breakpoint (frac=0).
//  Boundaries:
//   X=0 -> 0.
//   X=2^DSIZE-1 -> segment 15, max frac, no wrap.
//   Segment index never exceeds 15.
//  Reset mid-build or mid-stream: immediate clear of table, FSM and pipeline; build restarts on release.
// CONFIGURATION
//  CUBE_PWL_ROUND_EN defined: S3 adds 2^(DSIZE-5) to prod before the shift (round-half-up).
//  CUBE_PWL_ROUND_EN undefined: S3 truncates. Latency and the table are identical in both builds.
// STRUCTURE
//  Package cube_pwl_pkg holds:
//   SEG_BITS=4 and NPTS=17
//   typedef enum {S_SQ,S_CU,S_ST,S_DONE} cube_state_t
//   function sat_u(value, width) for the clamps
//  Sub-module cube_pwl_coef_gen: the build FSM plus the M/C register tables.
//   Outputs: cal_valid and the M/C table, read combinationally by the S1 lookup.
//  The top holds the 3-stage datapath only.
// TESTING
//  1) Release reset, X held 0 -> cal_valid=0 for 51 clks then 1; Y=0 throughout.
//  2) After cal_valid, peek the tables -> C1=16, C8=8192, C15=54000, M1=112, M15=11535; P16 clamps to 65535.
//  3) Breakpoints: X=0x1000 -> Y=16, X=0x8000 -> Y=8192, X=0 -> Y=0. Each appears exactly 3 clks after X is applied.
//  4) Interior/endpoint, truncating build:
//     - X=0x1800 -> 72
//     - X=0x1037 -> 17
//     - X=0xFFFF -> 65532 (no overflow/wrap)
//  5) Same as 4 with CUBE_PWL_ROUND_EN: X=0x1037 -> 18; X=0x1800 -> 72; X=0xFFFF -> 65532.
//  6) Ramp X += 65 per clk for 1000 clks. Then assert rst_n=0 mid-stream -> Y and cal_valid drop to 0
//     asynchronously; after release, a 51-cycle rebuild occurs; outputs must match the pre-reset run.
//     Checking: a scoreboard compares every Y against a reference model and checks it is monotonic non-decreasing.

Source files
------------

// File: rtl/cube_pwl_pkg.sv
// Shared constants, FSM state type and saturation helper for the piecewise-linear cube block.
package cube_pwl_pkg;

  localparam int SEG_BITS = 4;
  localparam int NSEG     = 1 << SEG_BITS;
  localparam int NPTS     = NSEG + 1;

  typedef enum logic [1:0] {S_SQ, S_CU, S_ST, S_DONE} cube_state_t;

  // Clamp an unsigned value to the largest number representable in 'width' bits.
  function automatic logic [63:0] sat_u(input logic [63:0] value, input int unsigned width);
    logic [63:0] maxv;
    maxv = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value > maxv) ? maxv : value;
  endfunction

endpackage

// File: rtl/cube_pwl_coef_gen.sv
// Builds the 17-point cube breakpoint table after reset: three clocks per point (square, cube, store),
// then raises cal_valid for good. Offsets C and slopes M are exposed as flat register tables.
module cube_pwl_coef_gen
  import cube_pwl_pkg::*;
#(
  parameter int DSIZE = 16
) (
  input  logic                       clock,
  input  logic                       rst_n,
  output logic                       cal_valid,
  output logic [NSEG-1:0][DSIZE-1:0] m_tab,
  output logic [NSEG-1:0][DSIZE-1:0] c_tab
);

  localparam int KW = $clog2(NPTS);

  cube_state_t         state;
  logic [KW-1:0]       k;
  logic [9:0]          sq;
  logic [14:0]         cu;
  logic [DSIZE-1:0]    p_k;
  logic [SEG_BITS-1:0] k_lo;
  logic [SEG_BITS-1:0] k_prev;

  // P_k = k^3 scaled so that k=16 lands at 2^DSIZE, which then clamps to all-ones.
  assign p_k    = DSIZE'(sat_u(64'(cu) << (DSIZE - 12), DSIZE));
  assign k_lo   = k[SEG_BITS-1:0];
  assign k_prev = SEG_BITS'(k - KW'(1));

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_SQ;
      k         <= '0;
      sq        <= '0;
      cu        <= '0;
      cal_valid <= 1'b0;
      m_tab     <= '0;
      c_tab     <= '0;
    end else begin
      case (state)
        S_SQ: begin
          sq    <= {5'b0, k} * {5'b0, k};
          state <= S_CU;
        end
        S_CU: begin
          cu    <= 15'(sq) * 15'(k);
          state <= S_ST;
        end
        S_ST: begin
          if (k < KW'(NSEG)) c_tab[k_lo] <= p_k;
          // Slope of the segment that ends at this breakpoint; C of its start is already stored.
          if (k != '0) m_tab[k_prev] <= p_k - c_tab[k_prev];
          if (k == KW'(NSEG)) begin
            state     <= S_DONE;
            cal_valid <= 1'b1;
          end else begin
            k     <= k + KW'(1);
            state <= S_SQ;
          end
        end
        default: begin
          state     <= S_DONE;
          cal_valid <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/cube_pwl.sv
// Piecewise-linear y = x^3 over unsigned fractions, 3-stage pipeline fed by the built coefficient table.
// Define CUBE_PWL_ROUND_EN for round-half-up in the final shift; default build truncates.
module cube_pwl
  import cube_pwl_pkg::*;
#(
  parameter int DSIZE = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] X,
  output logic [DSIZE-1:0] Y,
  output logic             cal_valid
);

  localparam int FW = DSIZE - SEG_BITS;
  localparam int PW = DSIZE + FW;

`ifdef CUBE_PWL_ROUND_EN
  localparam logic [PW:0] RND = (PW + 1)'(1) << (FW - 1);
`else
  localparam logic [PW:0] RND = '0;
`endif

  logic [NSEG-1:0][DSIZE-1:0] m_tab;
  logic [NSEG-1:0][DSIZE-1:0] c_tab;

  cube_pwl_coef_gen #(.DSIZE(DSIZE)) u_coef (
    .clock     (clock),
    .rst_n     (rst_n),
    .cal_valid (cal_valid),
    .m_tab     (m_tab),
    .c_tab     (c_tab)
  );

  logic [SEG_BITS-1:0] seg;
  logic [FW-1:0]       frac;
  logic [1:0]          vld_pipe;
  logic [DSIZE-1:0]    s1_m, s1_c, s2_c;
  logic [FW-1:0]       s1_f;
  logic [PW-1:0]       s2_prod;
  logic [PW:0]         prod_r;
  logic [DSIZE:0]      interp;
  logic [DSIZE+1:0]    sum;
  logic [DSIZE-1:0]    y_next;

  assign seg  = X[DSIZE-1 -: SEG_BITS];
  assign frac = X[FW-1:0];

  assign prod_r = {1'b0, s2_prod} + RND;
  assign interp = (DSIZE + 1)'(prod_r >> FW);
  assign sum    = (DSIZE + 2)'(s2_c) + (DSIZE + 2)'(interp);
  // Cannot exceed full scale with a monotone table; clamp anyway so a wrap is impossible.
  assign y_next = DSIZE'(sat_u(64'(sum), DSIZE));

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_m     <= '0;
      s1_c     <= '0;
      s1_f     <= '0;
      s2_prod  <= '0;
      s2_c     <= '0;
      Y        <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], cal_valid};
      if (cal_valid) begin
        s1_m <= m_tab[seg];
        s1_c <= c_tab[seg];
        s1_f <= frac;
      end else begin
        s1_m <= '0;
        s1_c <= '0;
        s1_f <= '0;
      end
      if (vld_pipe[0]) begin
        s2_prod <= PW'(s1_m) * PW'(s1_f);
        s2_c    <= s1_c;
      end else begin
        s2_prod <= '0;
        s2_c    <= '0;
      end
      Y <= vld_pipe[1] ? y_next : '0;
    end
  end

endmodule

// File: tb/tb_cube_pwl.sv
// Self-checking bench for cube_pwl (DSIZE=16): build timing, table contents, breakpoints,
// interior points, ramp scoreboard with monotonicity and a mid-stream reset/rebuild.
module tb_cube_pwl;

  localparam int DSIZE = 16;

  logic             clock;
  logic             rst_n;
  logic [DSIZE-1:0] X;
  logic [DSIZE-1:0] Y;
  logic             cal_valid;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int due;
    int val;
    int idx;
  } sb_t;

  sb_t sb_q[$];
  int  y_pre[1000];

  cube_pwl #(.DSIZE(DSIZE)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .X         (X),
    .Y         (Y),
    .cal_valid (cal_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 1;

  // Reference: exact breakpoints k^3*16 clamped, linear interpolation on 12 fractional bits.
  function automatic int model_y(input int x);
    longint p[17];
    longint t, y;
    int seg, frac;
    for (int k = 0; k < 17; k++) begin
      p[k] = longint'(k) * k * k * 16;
      if (p[k] > 65535) p[k] = 65535;
    end
    seg  = x / 4096;
    frac = x % 4096;
    t    = (p[seg + 1] - p[seg]) * frac;
`ifdef CUBE_PWL_ROUND_EN
    t    = t + 2048;
`endif
    y = p[seg] + t / 4096;
    if (y > 65535) y = 65535;
    return int'(y);
  endfunction

  task automatic wait_cal(output int n, output int y_nonzero);
    n = 0;
    y_nonzero = 0;
    while (cal_valid !== 1'b1 && n < 200) begin
      @(posedge clock);
      #1;
      n++;
      if (Y !== '0) y_nonzero = 1;
      X = DSIZE'($urandom);
    end
  endtask

  task automatic test_reset;
    int n, ynz;
    rst_n = 1'b0;
    X = '0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (Y !== '0) begin failures++; $display("FAIL reset_y actual=%0d expected=0", Y); end
    checks++;
    if (cal_valid !== 1'b0) begin failures++; $display("FAIL reset_cal actual=%b expected=0", cal_valid); end
    @(negedge clock);
    rst_n = 1'b1;
    n = 0;
    ynz = 0;
    while (cal_valid !== 1'b1 && n < 200) begin
      @(posedge clock);
      #1;
      n++;
      if (Y !== '0) ynz = 1;
    end
    checks++;
    if (n != 51) begin failures++; $display("FAIL build_cycles actual=%0d expected=51", n); end
    checks++;
    if (ynz != 0) begin failures++; $display("FAIL build_y_zero actual=nonzero expected=0"); end
    X = '0;
  endtask

  task automatic test_tables;
    int c1, c8, c15, m1, m15;
    c1  = int'(dut.u_coef.c_tab[1]);
    c8  = int'(dut.u_coef.c_tab[8]);
    c15 = int'(dut.u_coef.c_tab[15]);
    m1  = int'(dut.u_coef.m_tab[1]);
    m15 = int'(dut.u_coef.m_tab[15]);
    checks++; if (c1 != 16)    begin failures++; $display("FAIL tab_c1 actual=%0d expected=16", c1); end
    checks++; if (c8 != 8192)  begin failures++; $display("FAIL tab_c8 actual=%0d expected=8192", c8); end
    checks++; if (c15 != 54000) begin failures++; $display("FAIL tab_c15 actual=%0d expected=54000", c15); end
    checks++; if (m1 != 112)   begin failures++; $display("FAIL tab_m1 actual=%0d expected=112", m1); end
    checks++; if (m15 != 11535) begin failures++; $display("FAIL tab_m15 actual=%0d expected=11535", m15); end
    checks++; if (c15 + m15 != 65535) begin failures++; $display("FAIL tab_p16 actual=%0d expected=65535", c15 + m15); end
  endtask

  task automatic test_points(input string name, input int xs[], input int ys[]);
    sb_t e;
    int guard;
    foreach (xs[i]) begin
      X = DSIZE'(xs[i]);
      sb_q.push_back('{due: cyc + 3, val: ys[i], idx: i});
      @(posedge clock);
      #1;
      while (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        e = sb_q.pop_front();
        checks++;
        if (Y !== DSIZE'(e.val)) begin
          failures++;
          $display("FAIL %s[%0d] x=%h actual=%0d expected=%0d", name, e.idx, xs[e.idx], Y, e.val);
        end
      end
    end
    guard = 0;
    while (sb_q.size() > 0 && guard < 10) begin
      @(posedge clock);
      #1;
      guard++;
      while (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        e = sb_q.pop_front();
        checks++;
        if (Y !== DSIZE'(e.val)) begin
          failures++;
          $display("FAIL %s[%0d] x=%h actual=%0d expected=%0d", name, e.idx, xs[e.idx], Y, e.val);
        end
      end
    end
    checks++;
    if (sb_q.size() != 0) begin failures++; $display("FAIL %s_drain actual=%0d expected=0", name, sb_q.size()); end
    sb_q.delete();
  endtask

  // pass 0 records outputs; pass 1 also requires them to equal the pre-reset run.
  task automatic test_ramp(input int pass);
    sb_t e;
    int prev, guard;
    prev = 0;
    guard = 0;
    for (int i = 0; i < 1000 || (sb_q.size() > 0 && guard < 10); i++) begin
      if (i < 1000) begin
        X = DSIZE'(i * 65);
        sb_q.push_back('{due: cyc + 3, val: model_y(i * 65), idx: i});
      end else guard++;
      @(posedge clock);
      #1;
      while (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        e = sb_q.pop_front();
        checks++;
        if (Y !== DSIZE'(e.val)) begin
          failures++;
          $display("FAIL ramp%0d[%0d] actual=%0d expected=%0d", pass, e.idx, Y, e.val);
        end
        checks++;
        if (int'(Y) < prev) begin
          failures++;
          $display("FAIL ramp%0d_monotonic[%0d] actual=%0d expected>=%0d", pass, e.idx, Y, prev);
        end
        prev = int'(Y);
        if (pass == 0) y_pre[e.idx] = int'(Y);
        else begin
          checks++;
          if (int'(Y) != y_pre[e.idx]) begin
            failures++;
            $display("FAIL ramp_rerun[%0d] actual=%0d expected=%0d", e.idx, Y, y_pre[e.idx]);
          end
        end
      end
    end
    checks++;
    if (sb_q.size() != 0) begin failures++; $display("FAIL ramp%0d_drain actual=%0d expected=0", pass, sb_q.size()); end
    sb_q.delete();
  endtask

  task automatic test_reset_midstream;
    int n, ynz;
    X = 16'h9000;
    @(posedge clock);
    X = 16'hA123;
    @(posedge clock);
    @(posedge clock);
    #3;
    checks++;
    if (Y === '0) begin failures++; $display("FAIL pre_reset_y actual=0 expected=nonzero"); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (Y !== '0) begin failures++; $display("FAIL async_y actual=%0d expected=0", Y); end
    checks++;
    if (cal_valid !== 1'b0) begin failures++; $display("FAIL async_cal actual=%b expected=0", cal_valid); end
    @(negedge clock);
    rst_n = 1'b1;
    wait_cal(n, ynz);
    checks++;
    if (n != 51) begin failures++; $display("FAIL rebuild_cycles actual=%0d expected=51", n); end
    checks++;
    if (ynz != 0) begin failures++; $display("FAIL rebuild_y_zero actual=nonzero expected=0"); end
  endtask

  initial begin
    rst_n = 1'b0;
    X = '0;
    test_reset();
    test_tables();
    test_points("breakpoint", '{32'h1000, 32'h8000, 32'h0000}, '{16, 8192, 0});
`ifdef CUBE_PWL_ROUND_EN
    test_points("interior", '{32'h1800, 32'h1037, 32'hFFFF, 32'hF000}, '{72, 18, 65532, 54000});
`else
    test_points("interior", '{32'h1800, 32'h1037, 32'hFFFF, 32'hF000}, '{72, 17, 65532, 54000});
`endif
    test_ramp(0);
    test_reset_midstream();
    test_ramp(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
